// File: rtl/decoder_nto2n_seq.sv
// ---------------------------------------------------------------------------
// decoder_nto2n_seq
//   Registered N-to-2^N one-hot decoder with three operating modes:
//     DIRECT (00) : out <= 1<<in every cycle while enable is high.
//     STROBE (01) : a load produces a single-cycle one-hot pulse.
//     SCAN   (10) : self-timed walk of the one-hot bit from a start index,
//                   each position held SCAN_DWELL cycles.
//     11          : reserved, output forced to zero.
//   Used as a register-file write select and as a row-walk driver.
//
// Build option:
//   DECODER_SCAN_WRAP_EN - when defined, a scan wraps past 2^N-1 back to 0
//   and stops after the position just before its start index, so every scan
//   visits all 2^N positions. When undefined, a scan stops after 2^N-1.
//
// Parameters:
//   N          select width (1..6); out is 2**N bits wide
//   SCAN_DWELL cycles each scan position is held (>= 1)
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   enable   global enable; low zeroes out and freezes a running scan
//   mode     operating mode (see above)
//   in       select value, or scan start index
//   load     start request for STROBE / SCAN
//   out      registered one-hot (or zero) output
//   index    index of the asserted out bit; holds when out is zero
//   busy     high while a scan is running
//   done     one-cycle pulse after the final scan position
// ---------------------------------------------------------------------------

// Plain combinational binary-to-one-hot decode, one compare per output bit.
module decoder_nto2n_onehot #(
  parameter int N = 3
) (
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] hot
);
  for (genvar i = 0; i < 2**N; i++) begin : g_bit
    assign hot[i] = (sel == N'(i));
  end
endmodule

module decoder_nto2n_seq #(
  parameter int N          = 3,
  parameter int SCAN_DWELL = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [N-1:0]    in,
  input  logic            load,
  output logic [2**N-1:0] out,
  output logic [N-1:0]    index,
  output logic            busy,
  output logic            done
);

  localparam int W  = 2**N;
  localparam int DW = $clog2(SCAN_DWELL + 1);

  localparam logic [DW-1:0] DWELL_END = DW'(SCAN_DWELL);
  localparam logic [DW-1:0] DWELL_ONE = DW'(1);
  localparam logic [N-1:0]  IDX_LAST  = '1;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_STROBE = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            paused_q, paused_d;
  logic [W-1:0]    out_d;
  logic [N-1:0]    index_d;
  logic            busy_d, done_d;

  logic [N-1:0]    index_inc;
  logic [W-1:0]    hot_in, hot_idx, hot_inc;
  logic            last_step;

  // Increment wraps naturally in N bits; only the wrap build ever uses that.
  assign index_inc = index + N'(1);

  decoder_nto2n_onehot #(.N(N)) u_hot_in  (.sel(in),        .hot(hot_in));
  decoder_nto2n_onehot #(.N(N)) u_hot_idx (.sel(index),     .hot(hot_idx));
  decoder_nto2n_onehot #(.N(N)) u_hot_inc (.sel(index_inc), .hot(hot_inc));

`ifdef DECODER_SCAN_WRAP_EN
  // Scan ends once the next position would be the start position again.
  logic [N-1:0] start_q, start_d;
  assign last_step = (index_inc == start_q);
`else
  assign last_step = (index == IDX_LAST);
`endif

  // -------------------------------------------------------------------------
  // Next-state / next-output logic. Outputs default to zero-out, index hold,
  // busy/done low; each mode only states what differs.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    paused_d = 1'b0;
    out_d    = '0;
    index_d  = index;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef DECODER_SCAN_WRAP_EN
    start_d  = start_q;
`endif

    case (mode)
      MODE_DIRECT: begin
        // Any non-scan mode aborts a scan on the same edge, no done pulse.
        state_d = S_IDLE;
        dwell_d = '0;
        if (enable) begin
          out_d   = hot_in;
          index_d = in;
        end
      end

      MODE_STROBE: begin
        state_d = S_IDLE;
        dwell_d = '0;
        if (enable && load) begin
          out_d   = hot_in;
          index_d = in;
        end
      end

      MODE_SCAN: begin
        case (state_q)
          S_IDLE: begin
            if (enable && load) begin
              state_d = S_RUN;
              index_d = in;
              out_d   = hot_in;
              busy_d  = 1'b1;
              dwell_d = DWELL_ONE;
`ifdef DECODER_SCAN_WRAP_EN
              start_d = in;
`endif
            end
          end

          S_RUN: begin
            busy_d = 1'b1;
            if (!enable) begin
              // Frozen: out forced low, index/dwell/state untouched.
              paused_d = 1'b1;
            end else if (paused_q) begin
              // First enabled edge after a pause re-shows the frozen step
              // without consuming dwell, so the step resumes where it was.
              out_d = hot_idx;
            end else if (dwell_q < DWELL_END) begin
              dwell_d = dwell_q + DWELL_ONE;
              out_d   = hot_idx;
            end else if (!last_step) begin
              index_d = index_inc;
              out_d   = hot_inc;
              dwell_d = DWELL_ONE;
            end else begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              dwell_d = '0;
            end
          end

          S_DONE: begin
            // One-cycle done pulse; a load here is ignored.
            state_d = S_IDLE;
          end

          default: begin
            state_d = S_IDLE;
            dwell_d = '0;
          end
        endcase
      end

      default: begin
        // Reserved mode: zero output, index holds.
        state_d = S_IDLE;
        dwell_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      dwell_q  <= '0;
      paused_q <= 1'b0;
      out      <= '0;
      index    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef DECODER_SCAN_WRAP_EN
      start_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      paused_q <= paused_d;
      out      <= out_d;
      index    <= index_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef DECODER_SCAN_WRAP_EN
      start_q  <= start_d;
`endif
    end
  end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Bench for decoder_nto2n_seq. Three instances share one stimulus stream:
//   dut0: N=3 SCAN_DWELL=2, dut1: N=3 SCAN_DWELL=1, dut2: N=4 SCAN_DWELL=1.
// Every clock all three are compared with a scan model that tracks elapsed
// scan cycles and derives the position arithmetically.
module tb_decoder_nto2n_seq;

  localparam int NI = 3;
  localparam int NK [NI] = '{3, 3, 4};
  localparam int DK [NI] = '{2, 1, 1};
`ifdef DECODER_SCAN_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, enable, load;
  logic [1:0] mode;
  logic [3:0] in_v;

  logic [7:0]  out0, out1;
  logic [15:0] out2;
  logic [2:0]  idx0, idx1;
  logic [3:0]  idx2;
  logic        busy0, busy1, busy2, done0, done1, done2;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.N(3), .SCAN_DWELL(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .in(in_v[2:0]),
    .load(load), .out(out0), .index(idx0), .busy(busy0), .done(done0));
  decoder_nto2n_seq #(.N(3), .SCAN_DWELL(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .in(in_v[2:0]),
    .load(load), .out(out1), .index(idx1), .busy(busy1), .done(done1));
  decoder_nto2n_seq #(.N(4), .SCAN_DWELL(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .in(in_v),
    .load(load), .out(out2), .index(idx2), .busy(busy2), .done(done2));

  logic [15:0] o_out  [NI];
  logic [3:0]  o_idx  [NI];
  logic        o_busy [NI];
  logic        o_done [NI];
  assign o_out[0] = {8'h00, out0};  assign o_idx[0] = {1'b0, idx0};
  assign o_out[1] = {8'h00, out1};  assign o_idx[1] = {1'b0, idx1};
  assign o_out[2] = out2;           assign o_idx[2] = idx2;
  assign o_busy[0] = busy0; assign o_busy[1] = busy1; assign o_busy[2] = busy2;
  assign o_done[0] = done0; assign o_done[1] = done1; assign o_done[2] = done2;

  // ---------------- reference model ----------------
  logic [15:0] m_out [NI];
  int          m_idx [NI];
  bit          m_busy [NI], m_done [NI], m_run [NI], m_pause [NI];
  int          m_start [NI], m_el [NI], m_len [NI];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scan position = start + elapsed/dwell (mod 2^N); scan length is a
  // cycle count known at the start.
  task automatic model_step(input int k);
    int w, iv;
    bit was_done;
    w        = 1 << NK[k];
    iv       = int'(in_v) % w;
    was_done = m_done[k];
    if (!reset_n) begin
      m_out[k] = '0; m_idx[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      m_run[k] = 0;  m_pause[k] = 0;
      return;
    end
    m_done[k] = 0;
    if (mode != 2'b10) begin
      m_run[k] = 0; m_pause[k] = 0; m_busy[k] = 0; m_out[k] = '0;
      if (enable && (mode == 2'b00 || (mode == 2'b01 && load))) begin
        m_idx[k] = iv;
        m_out[k] = 16'(1) << iv;
      end
    end else if (m_run[k]) begin
      if (!enable) begin
        m_out[k] = '0; m_pause[k] = 1;
      end else if (m_pause[k]) begin
        m_pause[k] = 0; m_out[k] = 16'(1) << m_idx[k];
      end else begin
        m_el[k]++;
        if (m_el[k] == m_len[k]) begin
          m_run[k] = 0; m_busy[k] = 0; m_done[k] = 1; m_out[k] = '0;
        end else begin
          m_idx[k] = (m_start[k] + m_el[k] / DK[k]) % w;
          m_out[k] = 16'(1) << m_idx[k];
        end
      end
    end else begin
      m_out[k] = '0;
      if (!was_done && enable && load) begin
        m_run[k] = 1; m_pause[k] = 0; m_busy[k] = 1;
        m_start[k] = iv; m_el[k] = 0;
        m_len[k] = (WRAP ? w : (w - iv)) * DK[k];
        m_idx[k] = iv;
        m_out[k] = 16'(1) << iv;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("dut%0d out", k),   32'(o_out[k]),  32'(m_out[k]));
      chk($sformatf("dut%0d index", k), 32'(o_idx[k]),  32'(m_idx[k]));
      chk($sformatf("dut%0d busy", k),  32'(o_busy[k]), 32'(m_busy[k]));
      chk($sformatf("dut%0d done", k),  32'(o_done[k]), 32'(m_done[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_step(k);
    #1;
    check_all();
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       en;
    logic       ld;
    logic [3:0] in;
    logic [7:0] out;
    logic [2:0] idx;
  } vec_t;
  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] scan_exp [6];
    int         seq [20];
    int         n, prev_idx;
    bit         got_done;
    int         r;

    for (int k = 0; k < NI; k++) begin
      m_out[k] = '0; m_idx[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      m_run[k] = 0; m_pause[k] = 0; m_start[k] = 0; m_el[k] = 0; m_len[k] = 0;
    end
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; mode = 2'b00; in_v = 4'd0;

    // reset
    step(); step();
    chk("reset out", 32'(out1), 32'h0);
    chk("reset busy", 32'(busy1), 32'h0);
    chk("reset index", 32'(idx2), 32'h0);
    reset_n = 1'b1;

    // DIRECT / STROBE / reserved vectors (expected for the N=3 instances)
    tbl[0]  = '{2'b00, 1'b1, 1'b0, 4'd5, 8'h20, 3'd5};
    tbl[1]  = '{2'b00, 1'b0, 1'b0, 4'd2, 8'h00, 3'd5};
    tbl[2]  = '{2'b01, 1'b1, 1'b1, 4'd2, 8'h04, 3'd2};
    tbl[3]  = '{2'b01, 1'b1, 1'b0, 4'd3, 8'h00, 3'd2};
    tbl[4]  = '{2'b01, 1'b1, 1'b1, 4'd1, 8'h02, 3'd1};
    tbl[5]  = '{2'b01, 1'b1, 1'b1, 4'd6, 8'h40, 3'd6};
    tbl[6]  = '{2'b01, 1'b1, 1'b0, 4'd6, 8'h00, 3'd6};
    tbl[7]  = '{2'b11, 1'b1, 1'b1, 4'd3, 8'h00, 3'd6};
    tbl[8]  = '{2'b00, 1'b1, 1'b0, 4'd0, 8'h01, 3'd0};
    tbl[9]  = '{2'b00, 1'b1, 1'b0, 4'd7, 8'h80, 3'd7};
    tbl[10] = '{2'b01, 1'b0, 1'b1, 4'd4, 8'h00, 3'd7};
    for (int i = 0; i < 11; i++) begin
      mode = tbl[i].mode; enable = tbl[i].en; load = tbl[i].ld; in_v = tbl[i].in;
      step();
      chk($sformatf("vec%0d out", i),   32'(out1), 32'(tbl[i].out));
      chk($sformatf("vec%0d index", i), 32'(idx1), 32'(tbl[i].idx));
      chk($sformatf("vec%0d out n3d2", i), 32'(out0), 32'(tbl[i].out));
    end

    // scan, dwell 2, start 5; load during the scan is ignored
    scan_exp = '{8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80};
    mode = 2'b00; enable = 1'b1; load = 1'b0; in_v = 4'd0; step();
    mode = 2'b10; load = 1'b1; in_v = 4'd5; step();
    chk("scan5 first out", 32'(out0), 32'(scan_exp[0]));
    chk("scan5 first busy", 32'(busy0), 32'h1);
    for (int i = 1; i < 6; i++) begin
      load = (i < 3); in_v = 4'd1;
      step();
      chk($sformatf("scan5 out[%0d]", i), 32'(out0), 32'(scan_exp[i]));
      chk($sformatf("scan5 busy[%0d]", i), 32'(busy0), 32'h1);
    end
    step();
    chk("scan5 done", 32'(done0), 32'h1);
    chk("scan5 done out", 32'(out0), 32'h0);
    chk("scan5 done busy", 32'(busy0), 32'h0);
    step();
    chk("scan5 done cleared", 32'(done0), 32'h0);
    mode = 2'b00; in_v = 4'd0; step();

    // pause at index 3 (dwell 1, start 0)
    mode = 2'b10; load = 1'b1; in_v = 4'd0; step();
    load = 1'b0;
    step(); step(); step();
    chk("pause pre index", 32'(idx1), 32'd3);
    chk("pause pre out", 32'(out1), 32'h08);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause out", 32'(out1), 32'h0);
      chk("pause index", 32'(idx1), 32'd3);
      chk("pause busy", 32'(busy1), 32'h1);
    end
    enable = 1'b1; step();
    chk("resume out", 32'(out1), 32'h08);
    step();
    chk("resume next out", 32'(out1), 32'h10);
    mode = 2'b00; in_v = 4'd0; step();
    chk("cleanup busy", 32'(busy1), 32'h0);

    // abort by mode change at index 4
    mode = 2'b10; load = 1'b1; in_v = 4'd0; step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort pre index", 32'(idx1), 32'd4);
    mode = 2'b00; in_v = 4'd3; step();
    chk("abort busy", 32'(busy1), 32'h0);
    chk("abort done", 32'(done1), 32'h0);
    chk("abort direct out", 32'(out1), 32'h08);
    step();
    chk("abort no late done", 32'(done1), 32'h0);

    // reset mid-scan, N=4 start 2
    mode = 2'b10; load = 1'b1; in_v = 4'd2; step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rst pre index", 32'(idx2), 32'd6);
    reset_n = 1'b0; step();
    chk("rst out", 32'(out2), 32'h0);
    chk("rst index", 32'(idx2), 32'h0);
    chk("rst busy", 32'(busy2), 32'h0);
    chk("rst done", 32'(done2), 32'h0);
    reset_n = 1'b1; load = 1'b1; in_v = 4'd2; step();
    chk("rst rescan out", 32'(out2), 32'h0004);
    chk("rst rescan busy", 32'(busy2), 32'h1);
    load = 1'b0;
    got_done = 1'b0; prev_idx = 0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      prev_idx = int'(idx2);
      step();
      got_done = done2;
    end
    chk("rst rescan done seen", 32'(got_done), 32'h1);
    chk("rst rescan last index", 32'(prev_idx), WRAP ? 32'd1 : 32'd15);

    // wrap behaviour, N=3 dwell 1 start 6
    mode = 2'b00; in_v = 4'd0; step();
    mode = 2'b10; load = 1'b1; in_v = 4'd6; step();
    load = 1'b0;
    n = 0;
    while (busy1 && n < 20) begin
      seq[n] = int'(idx1);
      n++;
      step();
    end
    chk("wrap length", 32'(n), WRAP ? 32'd8 : 32'd2);
    chk("wrap done", 32'(done1), 32'h1);
    for (int i = 0; i < n && i < 8; i++)
      chk($sformatf("wrap index[%0d]", i), 32'(seq[i]), 32'((6 + i) % 8));

    // randomized phase, model-checked every cycle
    mode = 2'b10;
    for (int i = 0; i < 500; i++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      load    = ($urandom_range(0, 3) == 0);
      in_v    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, 9);
        mode = (r < 6) ? 2'b10 : (r < 8) ? 2'b00 : (r == 8) ? 2'b01 : 2'b11;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
